// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch and data) sharing one single-ported memory.
// Each grant runs IDLE -> ACCESS -> DONE; ties alternate between the ports.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the transaction
    logic              last_d_q, last_d_d;    // 1 = data port was granted most recently
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d_d    = last_d_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_write_d = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // On a tie the port that lost last time wins.
                    grant_d     = d_req && (!if_req || !last_d_q);
                    owner_d     = grant_d;
                    last_d_d    = grant_d;
                    addr_d      = grant_d ? d_addr : if_addr;
                    we_d        = grant_d && d_we;
                    wdata_d     = grant_d ? d_wdata : wdata_q;
                    mem_write_d = grant_d && d_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q)
                        d_rdata_d = mem_data;
                    else
                        if_rdata_d = mem_data;
                end
                d_done_d  = owner_q;
                if_done_d = !owner_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_d_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_write_q <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_d_q    <= last_d_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_write_q <= mem_write_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Latched address/data stay on the memory bus between transactions.
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write      = mem_write_q;
    assign if_done        = if_done_q;
    assign d_done         = d_done_q;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign busy           = busy_q;

endmodule
